// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and stream header size.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Little-endian 8-to-32 assembler; word and word_done are valid in the cycle the 4th byte arrives.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // Earlier bytes shift down so the first byte of a word lands in the low lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane  <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_valid) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_in, shreg[23:8]};
    end
  end

  assign word      = {byte_in, shreg};
  assign word_done = byte_valid && (lane == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Byte-stream image loader: writes instruction memory, verifies an XOR checksum, then releases the CPU.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy
);

  state_t            state, next_state;
  logic [7:0]        cnt_lo;
  logic [15:0]       word_cnt;
  logic [ADDR_W:0]   word_idx;
  logic [31:0]       csum;
  logic              accept;
  logic              asm_valid;
  logic [31:0]       asm_word;
  logic              word_done;
  logic [15:0]       count_n;
  logic              oversize;
  logic              last_word;

  assign rx_ready = rst_n && ((state == ST_IDLE) || (state == ST_CNT_HI) ||
                              (state == ST_DATA) || (state == ST_CSUM));
  assign accept    = rx_valid && rx_ready;
  assign asm_valid = accept && ((state == ST_DATA) || (state == ST_CSUM));
  assign count_n   = {rx_data, cnt_lo};
  assign oversize  = {1'b0, count_n} > 17'(MAX_WORDS);
  assign last_word = (17'(word_idx) + 17'd1) == {1'b0, word_cnt};

  // The same assembler serves data words and the trailing checksum word.
  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_CNT_HI;
      ST_CNT_HI: begin
        if (accept) begin
          if (oversize)            next_state = ST_ERR;
          else if (count_n == '0)  next_state = ST_CSUM;
          else                     next_state = ST_DATA;
        end
      end
      ST_DATA:   if (word_done && last_word) next_state = ST_CSUM;
      ST_CSUM:   if (word_done) next_state = (asm_word == csum) ? ST_RUN : ST_ERR;
      ST_RUN:    next_state = ST_RUN;
      ST_ERR:    next_state = ST_ERR;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Write port, word index and running checksum; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_lo     <= 8'd0;
      word_cnt   <= 16'd0;
      word_idx   <= '0;
      csum       <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept && (state == ST_IDLE))   cnt_lo   <= rx_data;
      if (accept && (state == ST_CNT_HI)) word_cnt <= count_n;
      if ((state == ST_DATA) && word_done) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_idx[ADDR_W-1:0];
        imem_wdata <= asm_word;
        csum       <= csum ^ asm_word;
        word_idx   <= word_idx + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign cpu_run  = (state == ST_RUN);
  assign load_err = (state == ST_ERR);
  assign busy     = (state == ST_CNT_HI) || (state == ST_DATA) || (state == ST_CSUM);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed vector table, corner sequences and randomized images.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic              busy;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  typedef wr_t wr_q_t[$];

  typedef struct {
    string        name;
    logic [111:0] bytes;
    int           len;
    int           gap;
    bit           exp_run;
    bit           exp_err;
    int           exp_writes;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  wr_t   got_wr[$];
  logic  prev_we   = 1'b0;
  bit    track_busy = 1'b0;
  bit    busy_bad   = 1'b0;

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Capture every memory write and confirm the strobe never lasts two cycles.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      got_wr.push_back('{imem_addr, imem_wdata});
      checkOutput("we_one_cycle", {31'd0, prev_we}, 32'd0);
    end
    if (track_busy && !busy) busy_bad = 1'b1;
    prev_we = imem_we;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: parse the stream by its format rules.
  task automatic model(input byte_q_t b, output wr_q_t w, output bit run, output bit err);
    int          n;
    int          base;
    logic [31:0] x;
    logic [31:0] word;
    logic [31:0] rx_csum;
    w   = {};
    run = 1'b0;
    err = 1'b0;
    x   = 32'd0;
    n   = int'(b[0]) + 256 * int'(b[1]);
    if (n > MAX_WORDS) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      base = 2 + 4 * k;
      word = {b[base+3], b[base+2], b[base+1], b[base]};
      w.push_back('{k[ADDR_W-1:0], word});
      x ^= word;
    end
    base    = 2 + 4 * n;
    rx_csum = {b[base+3], b[base+2], b[base+1], b[base]};
    run     = (rx_csum == x);
    err     = !run;
  endtask

  task automatic build_stream(input int n, input bit bad, output byte_q_t q);
    logic [31:0] x;
    logic [31:0] word;
    q = {};
    x = 32'd0;
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    if (n > MAX_WORDS) return;
    for (int k = 0; k < n; k++) begin
      word = $urandom;
      x ^= word;
      for (int j = 0; j < 4; j++) q.push_back(word[8*j +: 8]);
    end
    if (bad) x ^= (32'd1 << $urandom_range(31, 0));
    for (int j = 0; j < 4; j++) q.push_back(x[8*j +: 8]);
  endtask

  // Present bytes one at a time with random idle gaps; returns at posedge+1 after the last accept.
  task automatic applyStimulus(input byte_q_t bytes, input int max_gap, output int cycles);
    int gap;
    int t;
    cycles = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      rx_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
        cycles++;
      end
      rx_valid = 1'b1;
      rx_data  = bytes[i];
      t = 0;
      @(negedge clk);
      while (!rx_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rx_ready) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL rx_ready_timeout: byte %0d not accepted, got rx_ready 0, expected 1", i);
        rx_valid   = 1'b0;
        track_busy = 1'b0;
        return;
      end
      @(posedge clk); #1;
      cycles += 1 + t;
      track_busy = (i != bytes.size() - 1);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("rst_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    checkOutput("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    checkOutput("rst_load_err", {31'd0, load_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_wr.delete();
    busy_bad = 1'b0;
  endtask

  // Compare final flags and the captured write log against the model; call at posedge+1 after the last byte.
  task automatic check_result(input string tag, input byte_q_t q);
    wr_t exp_w[$];
    bit  exp_run;
    bit  exp_err;
    model(q, exp_w, exp_run, exp_err);
    @(negedge clk);
    checkOutput({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_run});
    checkOutput({tag, "_load_err"}, {31'd0, load_err}, {31'd0, exp_err});
    checkOutput({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    checkOutput({tag, "_wr_count"}, got_wr.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_wr.size(); i++) begin
      if (got_wr[i].addr !== exp_w[i].addr || got_wr[i].data !== exp_w[i].data) begin
        checkOutput({tag, "_wr_addr"}, 32'(got_wr[i].addr), 32'(exp_w[i].addr));
        checkOutput({tag, "_wr_data"}, got_wr[i].data, exp_w[i].data);
      end else begin
        n_checks++;
      end
    end
  endtask

  initial begin
    vec_t    vecs[5];
    byte_q_t q;
    byte_q_t head;
    int      cycles;
    int      n;
    int      gap;
    bit      bad;

    vecs[0] = '{"two_word", 112'h0200_44332211_DDCCBBAA_99FF99BB, 14, 0, 1'b1, 1'b0, 2, 32'h11223344, 32'hAABBCCDD};
    vecs[1] = '{"bad_csum", 112'h0200_44332211_DDCCBBAA_00000000, 14, 0, 1'b0, 1'b1, 2, 32'h11223344, 32'hAABBCCDD};
    vecs[2] = '{"empty",    112'h0000_00000000, 6, 0, 1'b1, 1'b0, 0, 32'd0, 32'd0};
    vecs[3] = '{"oversize", 112'h0101, 2, 0, 1'b0, 1'b1, 0, 32'd0, 32'd0};
    vecs[4] = '{"gapped",   112'h0200_44332211_DDCCBBAA_99FF99BB, 14, 5, 1'b1, 1'b0, 2, 32'h11223344, 32'hAABBCCDD};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      q = {};
      for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].bytes[8*(vecs[v].len-1-i) +: 8]);
      applyStimulus(q, vecs[v].gap, cycles);
      track_busy = 1'b0;
      @(negedge clk);
      checkOutput({vecs[v].name, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, vecs[v].exp_run});
      checkOutput({vecs[v].name, "_load_err"}, {31'd0, load_err}, {31'd0, vecs[v].exp_err});
      checkOutput({vecs[v].name, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
      checkOutput({vecs[v].name, "_busy_end"}, {31'd0, busy}, 32'd0);
      checkOutput({vecs[v].name, "_busy_held"}, {31'd0, busy_bad}, 32'd0);
      checkOutput({vecs[v].name, "_wr_count"}, got_wr.size(), vecs[v].exp_writes);
      if (got_wr.size() >= 2 && vecs[v].exp_writes == 2) begin
        checkOutput({vecs[v].name, "_wr0_addr"}, 32'(got_wr[0].addr), 32'd0);
        checkOutput({vecs[v].name, "_wr0_data"}, got_wr[0].data, vecs[v].w0);
        checkOutput({vecs[v].name, "_wr1_addr"}, 32'(got_wr[1].addr), 32'd1);
        checkOutput({vecs[v].name, "_wr1_data"}, got_wr[1].data, vecs[v].w1);
      end
      repeat (3) @(negedge clk);
      checkOutput({vecs[v].name, "_sticky"}, {30'd0, cpu_run, load_err}, {30'd0, vecs[v].exp_run, vecs[v].exp_err});
      @(posedge clk); #1;
    end

    // Reset after 6 bytes: the first write is visible, then everything clears and a reload succeeds.
    do_reset();
    q = {8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'hFF, 8'h99, 8'hBB};
    head = q[0:5];
    applyStimulus(head, 0, cycles);
    @(negedge clk);
    checkOutput("mid_we_latency", {31'd0, imem_we}, 32'd1);
    checkOutput("mid_we_addr", 32'(imem_addr), 32'd0);
    checkOutput("mid_we_data", imem_wdata, 32'h11223344);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_wr.delete();
    @(negedge clk);
    checkOutput("mid_post_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_post_addr", 32'(imem_addr), 32'd0);
    checkOutput("mid_post_wdata", imem_wdata, 32'd0);
    checkOutput("mid_post_flags", {29'd0, imem_we, cpu_run, load_err}, 32'd0);
    checkOutput("mid_post_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    head = q[0:12];
    applyStimulus(head, 0, cycles);
    @(negedge clk);
    checkOutput("reload_run_early", {31'd0, cpu_run}, 32'd0);
    @(posedge clk); #1;
    head = q[13:13];
    applyStimulus(head, 0, cycles);
    check_result("reload", q);

    // Largest legal image: last write lands on the top address.
    do_reset();
    build_stream(MAX_WORDS, 1'b0, q);
    applyStimulus(q, 0, cycles);
    checkOutput("max_load_cycles", cycles, HDR_BYTES + 4 * MAX_WORDS + 4);
    check_result("max_words", q);

    // Randomized images checked against the model.
    for (int it = 0; it < 30; it++) begin
      do_reset();
      n   = ($urandom_range(9, 0) == 0) ? int'($urandom_range(65535, MAX_WORDS + 1)) : int'($urandom_range(12, 0));
      bad = ($urandom_range(3, 0) == 0);
      gap = int'($urandom_range(3, 0));
      build_stream(n, bad, q);
      applyStimulus(q, gap, cycles);
      if (gap == 0 && n <= MAX_WORDS)
        checkOutput("rand_load_cycles", cycles, HDR_BYTES + 4 * n + 4);
      check_result("rand", q);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
